// File: rtl/cdb_arbiter_if.sv
// Bundle between the FU result registers, the CDB arbiter and the CDB/ROB write-back stage.
// The master side drives requests and squash; the arbiter (slave) returns grants and lanes.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 7,
    parameter int N       = 2,
    parameter int SW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   req;
    logic                 squash;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   stall;
    logic [N-1:0]         cdb_valid;
    logic [N-1:0][SW-1:0] cdb_src;

    modport master (
        output req,
        output squash,
        input  grant,
        input  stall,
        input  cdb_valid,
        input  cdb_src
    );

    modport slave (
        input  req,
        input  squash,
        output grant,
        output stall,
        output cdb_valid,
        output cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to N FU results per cycle by class priority
// (starving, MULT, LOAD, round-robin ALU) and registers the lane assignment.
module cdb_arbiter #(
    parameter int N         = 2,
    parameter int NUM_ALU   = 3,
    parameter int NUM_MULT  = 2,
    parameter int NUM_LOAD  = 2,
    parameter int AGE_LIMIT = 3,
    localparam int NUM_REQ  = NUM_ALU + NUM_MULT + NUM_LOAD,
    localparam int SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int AW       = $clog2(AGE_LIMIT + 1),
    localparam int RRW      = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1,
    localparam int LW       = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         starving;
    logic [N-1:0]               lane_v;
    logic [N-1:0][SW-1:0]       lane_src;
    logic [LW-1:0]              n_gnt;
    logic [RRW-1:0]             rr_ptr;
    logic [RRW-1:0]             rr_next;
    logic [NUM_REQ-1:0][AW-1:0] age;
    logic [N-1:0]               cdb_valid_q;
    logic [N-1:0][SW-1:0]       cdb_src_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starving[i] = (age[i] == AW'(AGE_LIMIT));
        end
    end

    // Four passes in class order; each candidate takes the next free lane.
    // A requester already taken in an earlier pass is skipped via gnt.
    always_comb begin
        logic [SW-1:0] idx;
        logic          elig;
        int            pos;
        gnt      = '0;
        lane_v   = '0;
        lane_src = '0;
        n_gnt    = '0;
        idx      = '0;
        elig     = 1'b0;
        pos      = 0;
        if (!reset && !bus.squash) begin
            for (int cls = 0; cls < 4; cls++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = SW'(k);
                    case (cls)
                        0: elig = starving[k];
                        1: elig = (k >= NUM_ALU) && (k < NUM_ALU + NUM_MULT);
                        2: elig = (k >= NUM_ALU + NUM_MULT);
                        default: begin
                            pos = int'(rr_ptr) + k;
                            if (pos >= NUM_ALU) begin
                                pos = pos - NUM_ALU;
                            end
                            idx  = SW'(pos);
                            elig = (k < NUM_ALU);
                        end
                    endcase
                    if (elig && bus.req[idx] && !gnt[idx] && (n_gnt < LW'(N))) begin
                        gnt[idx] = 1'b1;
                        for (int l = 0; l < N; l++) begin
                            if (LW'(l) == n_gnt) begin
                                lane_v[l]   = 1'b1;
                                lane_src[l] = idx;
                            end
                        end
                        n_gnt = n_gnt + 1'b1;
                    end
                end
            end
        end
    end

    // Walking the ALUs from rr_ptr, the last granted one seen is the last in RR order,
    // which also covers ALUs granted through the starving class.
    always_comb begin
        int p;
        rr_next = rr_ptr;
        p       = 0;
        for (int k = 0; k < NUM_ALU; k++) begin
            p = int'(rr_ptr) + k;
            if (p >= NUM_ALU) begin
                p = p - NUM_ALU;
            end
            if (gnt[SW'(p)]) begin
                rr_next = (p + 1 == NUM_ALU) ? '0 : RRW'(p + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr      <= '0;
            age         <= '0;
            cdb_valid_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr      <= rr_next;
            cdb_valid_q <= lane_v;
            cdb_src_q   <= lane_src;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && !gnt[i] && !bus.squash) begin
                    if (!starving[i]) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end else begin
                    age[i] <= '0;
                end
            end
        end
    end

    assign bus.grant     = gnt;
    assign bus.stall     = bus.req & ~gnt;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against
// a list-based priority model; a monitor checks the registered CDB lanes.
module tb_cdb_arbiter;
    localparam int N         = 2;
    localparam int NUM_ALU   = 3;
    localparam int NUM_MULT  = 2;
    localparam int NUM_LOAD  = 2;
    localparam int AGE_LIMIT = 3;
    localparam int NUM_REQ   = NUM_ALU + NUM_MULT + NUM_LOAD;
    localparam int SW        = $clog2(NUM_REQ);

    typedef struct {
        logic [N-1:0]    v;
        logic [N*SW-1:0] s;
    } cdb_t;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    cdb_t exp_q[$];
    int   age_m[NUM_REQ];
    int   rr_m;
    logic [NUM_REQ-1:0] m_grant;
    int   m_lanes[$];

    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .N(N), .SW(SW)) bus ();

    cdb_arbiter #(
        .N(N), .NUM_ALU(NUM_ALU), .NUM_MULT(NUM_MULT),
        .NUM_LOAD(NUM_LOAD), .AGE_LIMIT(AGE_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Priority list built class by class, then the first N entries win.
    function automatic void model_arb(input logic [NUM_REQ-1:0] r, input logic sq, input logic rst);
        int order[$];
        int a;
        order   = {};
        m_grant = '0;
        m_lanes = {};
        if (rst || sq) return;
        for (int i = 0; i < NUM_REQ; i++)
            if (r[i] && age_m[i] == AGE_LIMIT) order.push_back(i);
        for (int i = NUM_ALU; i < NUM_ALU + NUM_MULT; i++)
            if (r[i] && age_m[i] != AGE_LIMIT) order.push_back(i);
        for (int i = NUM_ALU + NUM_MULT; i < NUM_REQ; i++)
            if (r[i] && age_m[i] != AGE_LIMIT) order.push_back(i);
        for (int k = 0; k < NUM_ALU; k++) begin
            a = (rr_m + k) % NUM_ALU;
            if (r[a] && age_m[a] != AGE_LIMIT) order.push_back(a);
        end
        foreach (order[j]) begin
            if (m_lanes.size() < N) begin
                m_lanes.push_back(order[j]);
                m_grant[order[j]] = 1'b1;
            end
        end
    endfunction

    function automatic void model_advance(input logic [NUM_REQ-1:0] r, input logic sq, input logic rst);
        int best;
        int bestd;
        int d;
        if (rst) begin
            foreach (age_m[i]) age_m[i] = 0;
            rr_m = 0;
            return;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i] && !m_grant[i] && !sq)
                age_m[i] = (age_m[i] < AGE_LIMIT) ? age_m[i] + 1 : AGE_LIMIT;
            else
                age_m[i] = 0;
        end
        best  = -1;
        bestd = -1;
        for (int a = 0; a < NUM_ALU; a++) begin
            if (m_grant[a]) begin
                d = (a - rr_m + NUM_ALU) % NUM_ALU;
                if (d > bestd) begin
                    bestd = d;
                    best  = a;
                end
            end
        end
        if (best >= 0) rr_m = (best + 1) % NUM_ALU;
    endfunction

    task automatic cycle(input logic [NUM_REQ-1:0] r, input logic sq, input logic rst, input string tag);
        cdb_t e;
        @(negedge clock);
        bus.req    = r;
        bus.squash = sq;
        reset      = rst;
        #1;
        model_arb(r, sq, rst);
        chk({tag, " grant"}, 32'(bus.grant), 32'(m_grant));
        chk({tag, " stall"}, 32'(bus.stall), 32'(r & ~m_grant));
        e.v = '0;
        e.s = '0;
        foreach (m_lanes[k]) begin
            e.v[k]          = 1'b1;
            e.s[k*SW +: SW] = SW'(m_lanes[k]);
        end
        exp_q.push_back(e);
        model_advance(r, sq, rst);
    endtask

    initial begin
        cdb_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cdb_valid", 32'(bus.cdb_valid), 32'(e.v));
                chk("cdb_src", 32'(bus.cdb_src), 32'(e.s));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] r;
        logic [NUM_REQ-1:0] last_r;
        logic [NUM_REQ-1:0] keep;
        logic sq;
        logic rs;

        bus.req    = '0;
        bus.squash = 1'b0;
        reset      = 1'b1;
        foreach (age_m[i]) age_m[i] = 0;
        rr_m = 0;

        cycle('0, 1'b0, 1'b1, "reset");
        cycle('0, 1'b0, 1'b1, "reset");

        cycle('0, 1'b0, 1'b0, "idle");
        chk("idle grant const", 32'(bus.grant), 32'h0);
        chk("idle cdb_valid const", 32'(bus.cdb_valid), 32'h0);

        cycle(7'b0000111, 1'b0, 1'b0, "rr1");
        chk("rr1 grant const", 32'(bus.grant), 32'b0000011);
        chk("rr1 stall const", 32'(bus.stall), 32'b0000100);
        cycle(7'b0000111, 1'b0, 1'b0, "rr2");
        chk("rr1 lanes valid const", 32'(bus.cdb_valid), 32'b11);
        chk("rr1 lanes src const", 32'(bus.cdb_src), {26'd0, 3'd1, 3'd0});
        chk("rr2 grant const", 32'(bus.grant), 32'b0000101);
        cycle('0, 1'b0, 1'b0, "rr3");
        chk("rr2 lanes src const", 32'(bus.cdb_src), {26'd0, 3'd0, 3'd2});

        cycle(7'b0101001, 1'b0, 1'b0, "class");
        chk("class grant const", 32'(bus.grant), 32'b0101000);
        chk("class stall const", 32'(bus.stall), 32'b0000001);
        cycle('0, 1'b0, 1'b0, "class_after");
        chk("class lanes src const", 32'(bus.cdb_src), {26'd0, 3'd5, 3'd3});

        for (int c = 1; c <= 3; c++) begin
            cycle(7'b0011001, 1'b0, 1'b0, "starve");
            chk("starve mult grant const", 32'(bus.grant), 32'b0011000);
        end
        cycle(7'b0011001, 1'b0, 1'b0, "starve4");
        chk("starve4 grant const", 32'(bus.grant), 32'b0001001);
        cycle('0, 1'b0, 1'b0, "starve_after");
        chk("starve4 lanes src const", 32'(bus.cdb_src), {26'd0, 3'd3, 3'd0});

        cycle(7'b1111111, 1'b1, 1'b0, "squash");
        chk("squash grant const", 32'(bus.grant), 32'h0);
        chk("squash stall const", 32'(bus.stall), 32'b1111111);
        cycle('0, 1'b0, 1'b0, "squash_after");
        chk("squash cdb_valid const", 32'(bus.cdb_valid), 32'h0);

        cycle('0, 1'b0, 1'b1, "midreset_pre");
        cycle(7'b0000111, 1'b0, 1'b0, "midreset_rr");
        cycle(7'b0000111, 1'b0, 1'b1, "midreset");
        chk("midreset grant const", 32'(bus.grant), 32'h0);
        cycle(7'b0000111, 1'b0, 1'b0, "midreset_release");
        chk("release grant const", 32'(bus.grant), 32'b0000011);
        chk("release cdb_valid const", 32'(bus.cdb_valid), 32'h0);

        last_r = 7'b0000111;
        for (int n = 0; n < 600; n++) begin
            keep = last_r & ~m_grant;
            if ($urandom_range(0, 7) == 0) keep = keep & NUM_REQ'($urandom);
            r  = keep | (NUM_REQ'($urandom) & NUM_REQ'($urandom));
            sq = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 49) == 0);
            cycle(r, sq, rs, "rand");
            last_r = r;
        end

        cycle('0, 1'b0, 1'b0, "drain");
        repeat (2) @(negedge clock);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
